// File: rtl/ltsm_sb_hs_pkg.sv
// Shared types for the LTSM sideband request/response handshake engine:
// requester/responder state encodings, mode codes and the default timeout.
package ltsm_sb_hs_pkg;

  typedef enum logic [2:0] {
    R_IDLE,
    R_SEND,
    R_WAIT_TX,
    R_WAIT_RSP,
    R_DONE,
    R_ERR
  } req_state_t;

  typedef enum logic [2:0] {
    P_IDLE,
    P_WAIT_REQ,
    P_SEND,
    P_WAIT_TX,
    P_DONE,
    P_ERR
  } rsp_state_t;

  localparam logic [1:0] MODE_FULL     = 2'b00;
  localparam logic [1:0] MODE_RSP_ONLY = 2'b01;
  localparam logic [1:0] MODE_REQ_ONLY = 2'b10;

  // 8 ms at 100 MHz
  localparam int DEFAULT_TIMEOUT_CYCLES = 800000;

endpackage

// File: rtl/sb_hs_timer.sv
// Handshake timeout counter: counts enabled cycles and flags the cycle in
// which the count sits at TIMEOUT_CYCLES-1 while still enabled.
module sb_hs_timer #(
  parameter int TIMEOUT_W      = 20,
  parameter int TIMEOUT_CYCLES = 800000
) (
  input  logic clk,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam logic [TIMEOUT_W-1:0] LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  logic [TIMEOUT_W-1:0] cnt;

  // Saturates at LAST so a suppressed expiry can never wrap and re-fire.
  always_ff @(posedge clk) begin
    if (clear) begin
      cnt <= '0;
    end else if (count_en && (cnt != LAST)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = count_en && (cnt == LAST);

endmodule

// File: rtl/ltsm_sb_handshake.sv
// Sideband REQ/RSP handshake engine: concurrent requester and responder FSMs
// sharing one SB transmit path, with early-arrival latches and a sticky timeout.
module ltsm_sb_handshake
  import ltsm_sb_hs_pkg::*;
#(
  parameter int SB_MSG_WIDTH   = 4,
  parameter int TIMEOUT_W      = 20,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_en,
  input  logic [1:0]              i_mode,
  input  logic [SB_MSG_WIDTH-1:0] i_req_code,
  input  logic [SB_MSG_WIDTH-1:0] i_rsp_code,
  input  logic [SB_MSG_WIDTH-1:0] i_exp_req_code,
  input  logic [SB_MSG_WIDTH-1:0] i_exp_rsp_code,
  input  logic                    i_rx_msg_valid,
  input  logic [SB_MSG_WIDTH-1:0] i_decoded_SB_msg,
  input  logic                    i_SB_Busy,
  input  logic                    i_falling_edge_busy,
  output logic [SB_MSG_WIDTH-1:0] o_encoded_SB_msg,
  output logic                    o_tx_msg_valid,
  output logic                    o_hs_done,
  output logic                    o_timeout
);

  req_state_t r_state;
  rsp_state_t p_state;
  logic       req_seen;
  logic       rsp_seen;

  logic req_hit;
  logic rsp_hit;
  logic outstanding;
  logic grant_r;
  logic grant_p;
  logic r_fin;
  logic p_fin;
  logic all_done;
  logic expired;
  logic timeout_hit;
  logic count_en;
  logic timer_clear;

  assign req_hit     = i_rx_msg_valid && (i_decoded_SB_msg == i_exp_req_code);
  assign rsp_hit     = i_rx_msg_valid && (i_decoded_SB_msg == i_exp_rsp_code);
  assign outstanding = (r_state == R_WAIT_TX) || (p_state == P_WAIT_TX);
  assign all_done    = (r_state == R_DONE) && (p_state == P_DONE);

  // Sides that will be in DONE after this edge; completion beats an expiry
  // landing on the same edge.
  assign r_fin       = (r_state == R_DONE) || ((r_state == R_WAIT_RSP) && rsp_seen);
  assign p_fin       = (p_state == P_DONE) || ((p_state == P_WAIT_TX) && i_falling_edge_busy);
  assign timeout_hit = expired && !(r_fin && p_fin);

  // One message in flight at a time; the responder wins a simultaneous request.
  assign grant_p = i_en && !timeout_hit && (p_state == P_SEND) && !i_SB_Busy && !outstanding;
  assign grant_r = i_en && !timeout_hit && (r_state == R_SEND) && !i_SB_Busy && !outstanding
                   && (p_state != P_SEND);

  // The enable edge itself is not counted, so expiry lands exactly
  // TIMEOUT_CYCLES edges after i_en is first sampled high.
  assign timer_clear = i_rst || !i_en;
  assign count_en    = i_en && !o_hs_done && !o_timeout && !all_done && (r_state != R_IDLE);

  sb_hs_timer #(
    .TIMEOUT_W      (TIMEOUT_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (i_clk),
    .clear    (timer_clear),
    .count_en (count_en),
    .expired  (expired)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= R_IDLE;
    end else if (!i_en) begin
      r_state <= R_IDLE;
    end else if (timeout_hit) begin
      r_state <= R_ERR;
    end else begin
      case (r_state)
        R_IDLE:     r_state <= (i_mode == MODE_RSP_ONLY) ? R_DONE : R_SEND;
        R_SEND:     if (grant_r) r_state <= R_WAIT_TX;
        R_WAIT_TX:  if (i_falling_edge_busy) r_state <= R_WAIT_RSP;
        R_WAIT_RSP: if (rsp_seen) r_state <= R_DONE;
        default:    r_state <= r_state;
      endcase
    end
  end

  // A REQ arriving with the enable edge skips P_WAIT_REQ so the responder
  // contends for the SB alongside the requester's first send.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      p_state <= P_IDLE;
    end else if (!i_en) begin
      p_state <= P_IDLE;
    end else if (timeout_hit) begin
      p_state <= P_ERR;
    end else begin
      case (p_state)
        P_IDLE: begin
          if (i_mode == MODE_REQ_ONLY) p_state <= P_DONE;
          else if (req_hit)            p_state <= P_SEND;
          else                         p_state <= P_WAIT_REQ;
        end
        P_WAIT_REQ: if (req_seen) p_state <= P_SEND;
        P_SEND:     if (grant_p) p_state <= P_WAIT_TX;
        P_WAIT_TX:  if (i_falling_edge_busy) p_state <= P_DONE;
        default:    p_state <= p_state;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || !i_en) begin
      req_seen         <= 1'b0;
      rsp_seen         <= 1'b0;
      o_tx_msg_valid   <= 1'b0;
      o_encoded_SB_msg <= '0;
      o_hs_done        <= 1'b0;
      o_timeout        <= 1'b0;
    end else begin
      if (req_hit) req_seen <= 1'b1;
      if (rsp_hit) rsp_seen <= 1'b1;
      o_tx_msg_valid   <= grant_r || grant_p;
      o_encoded_SB_msg <= grant_p ? i_rsp_code : (grant_r ? i_req_code : '0);
      o_hs_done        <= all_done;
      if (timeout_hit) o_timeout <= 1'b1;
    end
  end

endmodule
